// File: rtl/s2p_pkg.sv
// s2p shared types and frame-length derivation.
// S2P_PARITY_EN appends one even-parity beat to every frame.
package s2p_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam int S2P_N_DEF = 8;

    function automatic int frame_len(input int n);
`ifdef S2P_PARITY_EN
        return n + 1;
`else
        return n;
`endif
    endfunction

endpackage

// File: rtl/s2p.sv
// Serial-to-parallel deserializer, LSB first, shift plus output register.
// Define S2P_PARITY_EN for a trailing even-parity beat and p_err.
module s2p
    import s2p_pkg::*;
#(
    parameter int N = S2P_N_DEF
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [N-1:0] p_data,
    output logic         p_valid,
    input  logic         p_ready,
    output logic         p_err
);

    localparam int FRAME = frame_len(N);
    localparam int CW    = $clog2(FRAME);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sreg;
    logic [N-1:0]  word;
    logic          s_fire;
    logic          last;
    logic          out_free;

    assign s_ready  = (state == COLLECT);
    assign s_fire   = s_valid & s_ready;
    assign out_free = !p_valid | p_ready;
    assign last     = (cnt == CW'(FRAME - 1));

`ifdef S2P_PARITY_EN
    logic par;
    logic err;

    // The final beat is parity only, so the data word is already complete.
    assign word = sreg;
    assign err  = par ^ s_data;
`else
    assign word  = {s_data, sreg[N-1:1]};
    assign p_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= COLLECT;
            cnt     <= '0;
            sreg    <= '0;
            p_data  <= '0;
            p_valid <= 1'b0;
`ifdef S2P_PARITY_EN
            par     <= 1'b0;
            p_err   <= 1'b0;
`endif
        end else begin
            if (p_valid && p_ready) begin
                p_valid <= 1'b0;
            end
            unique case (state)
                COLLECT: begin
                    if (s_fire && !last) begin
                        sreg <= {s_data, sreg[N-1:1]};
                        cnt  <= cnt + 1'b1;
`ifdef S2P_PARITY_EN
                        par  <= par ^ s_data;
`endif
                    end else if (s_fire && out_free) begin
                        p_data  <= word;
                        p_valid <= 1'b1;
                        cnt     <= '0;
`ifdef S2P_PARITY_EN
                        p_err   <= err;
                        par     <= 1'b0;
`endif
                    end else if (s_fire) begin
                        state <= HOLD;
`ifdef S2P_PARITY_EN
                        par   <= err;
`else
                        sreg  <= word;
`endif
                    end
                end
                HOLD: begin
                    if (out_free) begin
                        p_data  <= sreg;
                        p_valid <= 1'b1;
                        cnt     <= '0;
                        state   <= COLLECT;
`ifdef S2P_PARITY_EN
                        p_err   <= par;
                        par     <= 1'b0;
`endif
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_s2p.sv
// Bench for s2p: directed literal checks plus randomized
// frames against a queue-based model of completed words.
module tb_s2p;

    localparam int N = 8;
`ifdef S2P_PARITY_EN
    localparam int FRAME = N + 1;
`else
    localparam int FRAME = N;
`endif

    typedef struct {
        logic [N-1:0] d;
        logic         e;
    } word_t;

    logic         clk;
    logic         rstn;
    logic         s_data;
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] p_data;
    logic         p_valid;
    logic         p_ready;
    logic         p_err;

    int    n_cmp;
    int    n_bad;
    bit    armed;
    bit    rand_pr;
    word_t q[$];
    logic  bits[$];

    s2p #(.N(N)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .p_data (p_data),
        .p_valid(p_valid),
        .p_ready(p_ready),
        .p_err  (p_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: outstanding words are those completed but not yet consumed.
    // At most one sits in the output, at most one more waits behind it.
    always @(negedge clk) begin
        if (armed) begin
            chk("p_valid", 32'(p_valid), 32'(q.size() != 0));
            chk("s_ready", 32'(s_ready), 32'(q.size() < 2));
            if (p_valid && q.size() != 0) begin
                chk("p_data", 32'(p_data), 32'(q[0].d));
                chk("p_err", 32'(p_err), 32'(q[0].e));
            end
        end
        if (!rstn) begin
            q.delete();
            bits.delete();
            armed = 1'b1;
        end else begin
            if (p_valid && p_ready && q.size() != 0)
                void'(q.pop_front());
            if (s_valid && s_ready) begin
                bits.push_back(s_data);
                if (bits.size() == FRAME) begin
                    word_t w;
                    w.e = 1'b0;
                    for (int i = 0; i < FRAME; i++) begin
                        if (i < N) w.d[i] = bits[i];
                        w.e = w.e ^ bits[i];
                    end
`ifndef S2P_PARITY_EN
                    w.e = 1'b0;
`endif
                    q.push_back(w);
                    bits.delete();
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_pr) p_ready = ($urandom_range(0, 2) != 0);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send_bit(input logic b);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && n < 100) begin
            tick(1);
            n++;
        end
        if (!s_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_bit: s_ready stuck %0d expected 1", s_ready);
        end
        tick(1);
        s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [N-1:0] w, input logic bad_par,
                             input int max_gap);
        for (int i = 0; i < N; i++) begin
            if (max_gap > 0) tick($urandom_range(0, max_gap));
            send_bit(w[i]);
        end
`ifdef S2P_PARITY_EN
        if (max_gap > 0) tick($urandom_range(0, max_gap));
        send_bit((^w) ^ bad_par);
`else
        if (bad_par) tick(0);
`endif
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        armed   = 1'b0;
        rand_pr = 1'b0;
        rstn    = 1'b0;
        s_valid = 1'b0;
        s_data  = 1'b0;
        p_ready = 1'b0;
        tick(2);
        rstn = 1'b1;

        chk("rst_p_valid", 32'(p_valid), 0);
        chk("rst_p_data", 32'(p_data), 0);
        chk("rst_p_err", 32'(p_err), 0);
        chk("rst_s_ready", 32'(s_ready), 1);
        tick(5);
        chk("idle_p_valid", 32'(p_valid), 0);

        // Single word 62.
        p_ready = 1'b1;
        send_word(8'd62, 1'b0, 0);
        chk("single_valid", 32'(p_valid), 1);
        chk("single_data", 32'(p_data), 62);
        tick(1);
        chk("single_drop", 32'(p_valid), 0);

        // Back-to-back 62, 52.
        send_word(8'd62, 1'b0, 0);
        chk("b2b_first", 32'(p_data), 62);
        send_word(8'd52, 1'b0, 0);
        chk("b2b_second", 32'(p_data), 52);
        chk("b2b_valid", 32'(p_valid), 1);
        tick(2);

        // Backpressure: 7 held, 52 waits in HOLD.
        p_ready = 1'b0;
        send_word(8'd7, 1'b0, 0);
        send_word(8'd52, 1'b0, 0);
        chk("bp_hold_ready", 32'(s_ready), 0);
        chk("bp_hold_data", 32'(p_data), 7);
        tick(3);
        chk("bp_stable", 32'(p_data), 7);
        p_ready = 1'b1;
        tick(1);
        chk("bp_next_data", 32'(p_data), 52);
        chk("bp_next_valid", 32'(p_valid), 1);
        chk("bp_ready_back", 32'(s_ready), 1);
        tick(1);
        chk("bp_drained", 32'(p_valid), 0);

        // Reset mid-word discards the partial frame.
        for (int i = 0; i < 5; i++) send_bit(1'(8'd62 >> i));
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        chk("mid_rst_valid", 32'(p_valid), 0);
        send_word(8'd52, 1'b0, 0);
        chk("mid_rst_data", 32'(p_data), 52);
        tick(2);

`ifdef S2P_PARITY_EN
        send_word(8'd62, 1'b0, 0);
        chk("par_ok_data", 32'(p_data), 62);
        chk("par_ok_err", 32'(p_err), 0);
        send_word(8'd62, 1'b1, 0);
        chk("par_bad_data", 32'(p_data), 62);
        chk("par_bad_err", 32'(p_err), 1);
        tick(2);
`endif

        // Randomized frames with idle gaps and random p_ready.
        rand_pr = 1'b1;
        for (int k = 0; k < 300; k++) begin
            send_word(N'($urandom), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 1) == 0) ? 0 : 2);
            if ($urandom_range(0, 9) == 0) tick($urandom_range(1, 12));
        end
        rand_pr = 1'b0;
        p_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) tick(1);
        chk("drain", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
